// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, CONR bit positions, word type.
package ebus_pkg;

    typedef enum logic [1:0] {
        CONO  = 2'd0,
        CONI  = 2'd1,
        DATAO = 2'd2,
        DATAI = 2'd3
    } ebus_func_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2
    } ebus_state_t;

    localparam int CONR_DONE_BIT     = 32;
    localparam int CONR_CLR_DONE_BIT = 31;
    localparam int CONR_PAR_ERR_BIT  = 18;
    localparam int CONR_PIA_LSB      = 33;

    typedef logic [0:35] ebus_word_t;

endpackage

// File: rtl/ebus_pi_decode.sv
// Registered PIA decode: one-hot PI request on levels 1..7, level 0 means none.
module ebus_pi_decode (
    input  logic       clk_h,
    input  logic       mr_reset_h,
    input  logic [2:0] pia_h,
    input  logic       en_h,
    output logic [1:7] pi_h
);

    logic [1:7] pi_d;
    logic [1:7] pi_q;

    always_comb begin
        pi_d = '0;
        for (int i = 1; i <= 7; i++) begin
            pi_d[i] = en_h && (pia_h == 3'(i));
        end
    end

    always_ff @(posedge clk_h) begin
        if (mr_reset_h) begin
            pi_q <= '0;
        end else begin
            pi_q <= pi_d;
        end
    end

    assign pi_h = pi_q;

endmodule

// File: rtl/ebus_dev_responder.sv
// EBUS device-side responder: CONO/CONI/DATAO/DATAI decode, CONR status, PI request.
// Optional inbound/outbound odd parity with PAR ERR in CONR bit 18: EBUS_DEV_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for demand addressed to DEV_CS with a known function
// SETUP | data setup countdown; read data driven from entry
// XFER  | transfer acknowledged; side effects in first cycle only
module ebus_dev_responder
    import ebus_pkg::*;
#(
    parameter logic [6:0] DEV_CS       = 7'o004,
    parameter int         SETUP_CYCLES = 2
) (
    input  logic        clk_h,
    input  logic        mr_reset_h,
    input  logic [0:6]  ebus_cs_h,
    input  logic [0:2]  ebus_func_h,
    input  logic        ebus_demand_h,
    input  logic [0:35] ebus_d_in_h,
    output logic [0:35] ebus_d_out_h,
    output logic        ebus_d_oe_h,
    output logic        ebus_xfer_h,
    output logic [1:7]  ebus_pi_h,
`ifdef EBUS_DEV_PARITY_EN
    input  logic        ebus_par_in_h,
    output logic        ebus_par_out_h,
`endif
    input  logic [0:17] dev_status_h,
    input  logic        dev_done_h,
    input  logic [0:35] datai_word_h,
    output logic        datai_taken_h,
    output logic [0:35] datao_word_h,
    output logic        datao_strobe_h
);

    localparam logic [3:0] CNT_INIT = 4'(SETUP_CYCLES - 1);

    ebus_state_t state_q, state_d;
    ebus_func_t  func_q, func_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    ebus_word_t  rdata_q, rdata_d;
    logic [18:35] conr_q, conr_d;
    ebus_word_t  datao_q, datao_d;
    logic        strobe_q, strobe_d;
    logic        taken_q, taken_d;

    logic qualified;
    logic is_read;
    logic fire;

    assign qualified = ebus_demand_h && (ebus_cs_h == DEV_CS) && !ebus_func_h[0];
    assign is_read   = (func_q == CONI) || (func_q == DATAI);
    assign fire      = (state_q == ST_XFER) && first_q;

`ifdef EBUS_DEV_PARITY_EN
    logic par_bad;
    assign par_bad = !(^{ebus_d_in_h, ebus_par_in_h});
`endif

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (qualified) begin
                    func_d  = ebus_func_t'(ebus_func_h[1:2]);
                    rdata_d = (ebus_func_h[1:2] == 2'd1) ? {dev_status_h, conr_q} : datai_word_h;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!ebus_demand_h) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_XFER;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_XFER: begin
                if (!ebus_demand_h) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        conr_d   = conr_q;
        datao_d  = datao_q;
        strobe_d = 1'b0;
        taken_d  = 1'b0;
        if (fire) begin
            case (func_q)
                CONO: begin
                    conr_d = ebus_d_in_h[18:35];
                    conr_d[CONR_CLR_DONE_BIT] = 1'b0;
                    if (ebus_d_in_h[CONR_CLR_DONE_BIT]) begin
                        conr_d[CONR_DONE_BIT] = 1'b0;
                    end
`ifdef EBUS_DEV_PARITY_EN
                    conr_d[CONR_PAR_ERR_BIT] = ebus_d_in_h[CONR_PAR_ERR_BIT] ? 1'b0
                                                                              : conr_q[CONR_PAR_ERR_BIT];
                    if (par_bad) begin
                        conr_d[CONR_PAR_ERR_BIT] = 1'b1;
                    end
`endif
                end
                DATAO: begin
                    datao_d  = ebus_d_in_h;
                    strobe_d = 1'b1;
`ifdef EBUS_DEV_PARITY_EN
                    if (par_bad) begin
                        conr_d[CONR_PAR_ERR_BIT] = 1'b1;
                    end
`endif
                end
                DATAI:   taken_d = 1'b1;
                default: ;
            endcase
        end
        // A device completion in the same cycle as a CONO clear must not be lost.
        if (dev_done_h) begin
            conr_d[CONR_DONE_BIT] = 1'b1;
        end
    end

    always_ff @(posedge clk_h) begin
        if (mr_reset_h) begin
            state_q  <= ST_IDLE;
            func_q   <= CONO;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            rdata_q  <= '0;
            conr_q   <= '0;
            datao_q  <= '0;
            strobe_q <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            rdata_q  <= rdata_d;
            conr_q   <= conr_d;
            datao_q  <= datao_d;
            strobe_q <= strobe_d;
            taken_q  <= taken_d;
        end
    end

    ebus_pi_decode u_pi_decode (
        .clk_h      (clk_h),
        .mr_reset_h (mr_reset_h),
        .pia_h      (conr_q[CONR_PIA_LSB +: 3]),
        .en_h       (conr_q[CONR_DONE_BIT]),
        .pi_h       (ebus_pi_h)
    );

    assign ebus_xfer_h    = (state_q == ST_XFER);
    assign ebus_d_oe_h    = (state_q != ST_IDLE) && is_read;
    assign ebus_d_out_h   = ebus_d_oe_h ? rdata_q : '0;
    assign datao_word_h   = datao_q;
    assign datao_strobe_h = strobe_q;
    assign datai_taken_h  = taken_q;

`ifdef EBUS_DEV_PARITY_EN
    assign ebus_par_out_h = ebus_d_oe_h && !(^ebus_d_out_h);
`endif

endmodule
